blake_msg_init: RTL and testbench

Front end of the BLAKE-512 core, the producing side of the round-state interface that finalization consumes. Accepts the message as a stream of big-endian 64-bit words and assembles 1024-bit blocks. Applies BLAKE-512 padding and tracks the 128-bit bit counter. Per block it builds the initial 16-word state (chain value, constants, counter) and pulses `init_round`, then waits for the round engine's `count_done` before building the next block.

---
 rtl/blake_msg_init_if.sv | 26 ++
 rtl/blake_msg_init.sv | 234 +++++++++++++++++++++++
 tb/tb_blake_msg_init.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blake_msg_init_if.sv
// Message-side handshake, chaining input and round-state outputs of the
// BLAKE-512 front end, grouped so source and core share one bundle.
interface blake_msg_init_if;
    logic [63:0]   din;
    logic          din_valid;
    logic          din_ready;
    logic          din_last;
    logic [3:0]    din_bytes;
    logic [511:0]  h_chain;
    logic          count_done;
    logic          init_round;
    logic [1023:0] v_state_init;
    logic [1023:0] m_block;
    logic          last_block;
    logic          busy;

    modport master (
        output din, din_valid, din_last, din_bytes, h_chain, count_done,
        input  din_ready, init_round, v_state_init, m_block, last_block, busy
    );

    modport slave (
        input  din, din_valid, din_last, din_bytes, h_chain, count_done,
        output din_ready, init_round, v_state_init, m_block, last_block, busy
    );
endinterface

// File: rtl/blake_msg_init.sv
// BLAKE-512 front end: packs big-endian message words into 1024-bit blocks,
// applies BLAKE padding (with an optional extra block), keeps the 128-bit
// bit counter and builds the 16-word initial round state for each block.
module blake_msg_init (
    input  logic            clk,
    input  logic            rstb,
    blake_msg_init_if.slave bus
);
    typedef enum logic [2:0] {
        S_FILL   = 3'd0,
        S_BUILD  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_SETTLE = 3'd4
    } state_e;

    localparam logic [511:0] IV512 = {
        64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B, 64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
        64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F, 64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179};
    localparam logic [255:0] C_0_3 = {
        64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89};
    localparam logic [63:0] C4 = 64'h452821E638D01377;
    localparam logic [63:0] C5 = 64'hBE5466CF34E90C6C;
    localparam logic [63:0] C6 = 64'hC0AC29B7C97C50DD;
    localparam logic [63:0] C7 = 64'h3F84D5B5B5470917;

    // Keeps the nb most significant bytes of a word (nb >= 8 keeps all).
    function automatic logic [63:0] keep_mask(input logic [3:0] nb);
        if (nb >= 4'd8) begin
            keep_mask = {64{1'b1}};
        end else begin
            keep_mask = ~({64{1'b1}} >> {nb[2:0], 3'b000});
        end
    endfunction

    // Block-sized vector with 0x80 at byte index pb; zero when pb is past the block.
    function automatic logic [1023:0] pad_byte(input logic [7:0] pb);
        pad_byte = '0;
        for (int k = 0; k < 128; k++) begin
            if (pb == 8'(k)) begin
                pad_byte[1023 - 8*k -: 8] = 8'h80;
            end else begin
                pad_byte[1023 - 8*k -: 8] = pad_byte[1023 - 8*k -: 8];
            end
        end
    endfunction

    state_e         state_q, state_d;
    logic [1023:0]  m_q, m_d;
    logic [3:0]     widx_q, widx_d;
    logic [7:0]     blk_bytes_q, blk_bytes_d;   // message bytes in current block (p+1)
    logic [127:0]   bitcnt_q, bitcnt_d;
    logic           first_q, first_d;
    logic           ended_q, ended_d;           // message ended in the current block
    logic           extra_pend_q, extra_pend_d;
    logic           extra80_q, extra80_d;       // extra block carries the 0x80 marker
    logic           do_extra_q, do_extra_d;     // next BUILD produces the extra block
    logic           din_ready_q, din_ready_d;
    logic           init_round_q, init_round_d;
    logic           busy_q, busy_d;
    logic           last_block_q, last_block_d;
    logic [1023:0]  v_q, v_d;
    logic [1023:0]  m_out_q, m_out_d;

    logic [3:0]     nb_s;
    logic [63:0]    word_s;
    logic [1023:0]  blk_s;
    logic [127:0]   t_s;

    // State, block assembly, padding and round-state construction.
    always_comb begin
        state_d      = state_q;
        m_d          = m_q;
        widx_d       = widx_q;
        blk_bytes_d  = blk_bytes_q;
        bitcnt_d     = bitcnt_q;
        first_d      = first_q;
        ended_d      = ended_q;
        extra_pend_d = extra_pend_q;
        extra80_d    = extra80_q;
        do_extra_d   = do_extra_q;
        last_block_d = last_block_q;
        v_d          = v_q;
        m_out_d      = m_out_q;
        nb_s         = 4'd8;
        word_s       = 64'd0;
        blk_s        = m_q;
        t_s          = 128'd0;

        case (state_q)
            S_FILL: begin
                if (bus.din_valid && din_ready_q) begin
                    if (bus.din_last) begin
                        nb_s = (bus.din_bytes > 4'd8) ? 4'd8 : bus.din_bytes;
                    end else begin
                        nb_s = 4'd8;
                    end
                    word_s = bus.din & keep_mask(nb_s);
                    for (int w = 0; w < 16; w++) begin
                        if (widx_q == 4'(w)) begin
                            m_d[1023 - 64*w -: 64] = word_s;
                        end else begin
                            m_d[1023 - 64*w -: 64] = m_q[1023 - 64*w -: 64];
                        end
                    end
                    widx_d      = widx_q + 4'd1;
                    blk_bytes_d = blk_bytes_q + {4'd0, nb_s};
                    bitcnt_d    = bitcnt_q + {121'd0, nb_s, 3'b000};
                    ended_d     = ended_q | bus.din_last;
                    if (bus.din_last || (widx_q == 4'd15)) begin
                        state_d = S_BUILD;
                    end else begin
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
            S_BUILD: begin
                if (do_extra_q) begin
                    blk_s = '0;
                    blk_s[1023 -: 8] = extra80_q ? 8'h80 : 8'h00;
                    blk_s[135 -: 8]  = 8'h01;
                    blk_s[127:0]     = bitcnt_q;
                    t_s          = 128'd0;
                    last_block_d = 1'b1;
                    do_extra_d   = 1'b0;
                end else begin
                    blk_s = m_q;
                    t_s   = (blk_bytes_q != 8'd0) ? bitcnt_q : 128'd0;
                    if (ended_q && (blk_bytes_q <= 8'd111)) begin
                        blk_s           = blk_s | pad_byte(blk_bytes_q);
                        blk_s[135 -: 8] = blk_s[135 -: 8] | 8'h01;
                        blk_s[127:0]    = bitcnt_q;
                        last_block_d    = 1'b1;
                    end else if (ended_q) begin
                        blk_s        = blk_s | pad_byte(blk_bytes_q);
                        extra_pend_d = 1'b1;
                        extra80_d    = (blk_bytes_q == 8'd128);
                        last_block_d = 1'b0;
                    end else begin
                        last_block_d = 1'b0;
                    end
                end
                m_out_d = blk_s;
                v_d     = {first_q ? IV512 : bus.h_chain, C_0_3,
                           t_s[63:0] ^ C4, t_s[63:0] ^ C5,
                           t_s[127:64] ^ C6, t_s[127:64] ^ C7};
                first_d = 1'b0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.count_done) begin
                    state_d = S_SETTLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_SETTLE: begin
                widx_d      = 4'd0;
                blk_bytes_d = 8'd0;
                m_d         = '0;
                if (extra_pend_q) begin
                    extra_pend_d = 1'b0;
                    do_extra_d   = 1'b1;
                    state_d      = S_BUILD;
                end else if (last_block_q) begin
                    bitcnt_d = 128'd0;
                    first_d  = 1'b1;
                    ended_d  = 1'b0;
                    state_d  = S_FILL;
                end else begin
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase

        din_ready_d  = (state_d == S_FILL);
        init_round_d = (state_d == S_ISSUE);
        busy_d       = (state_d != S_FILL);
    end

    // State and output registers; reset discards any partial or pending block.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q      <= S_FILL;
            m_q          <= '0;
            widx_q       <= 4'd0;
            blk_bytes_q  <= 8'd0;
            bitcnt_q     <= 128'd0;
            first_q      <= 1'b1;
            ended_q      <= 1'b0;
            extra_pend_q <= 1'b0;
            extra80_q    <= 1'b0;
            do_extra_q   <= 1'b0;
            din_ready_q  <= 1'b0;
            init_round_q <= 1'b0;
            busy_q       <= 1'b0;
            last_block_q <= 1'b0;
            v_q          <= '0;
            m_out_q      <= '0;
        end else begin
            state_q      <= state_d;
            m_q          <= m_d;
            widx_q       <= widx_d;
            blk_bytes_q  <= blk_bytes_d;
            bitcnt_q     <= bitcnt_d;
            first_q      <= first_d;
            ended_q      <= ended_d;
            extra_pend_q <= extra_pend_d;
            extra80_q    <= extra80_d;
            do_extra_q   <= do_extra_d;
            din_ready_q  <= din_ready_d;
            init_round_q <= init_round_d;
            busy_q       <= busy_d;
            last_block_q <= last_block_d;
            v_q          <= v_d;
            m_out_q      <= m_out_d;
        end
    end

    assign bus.din_ready    = din_ready_q;
    assign bus.init_round   = init_round_q;
    assign bus.busy         = busy_q;
    assign bus.last_block   = last_block_q;
    assign bus.v_state_init = v_q;
    assign bus.m_block      = m_out_q;
endmodule

// File: tb/tb_blake_msg_init.sv
// Scoreboard bench for blake_msg_init: directed messages push hand-computed
// blocks into a queue, a negedge monitor compares them on every init_round.
module tb_blake_msg_init;
    logic clk = 1'b0;
    logic rstb;

    blake_msg_init_if bus();

    blake_msg_init dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    localparam logic [511:0] IVV = {
        64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B, 64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
        64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F, 64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179};
    localparam logic [63:0] C0 = 64'h243F6A8885A308D3;
    localparam logic [63:0] C1 = 64'h13198A2E03707344;
    localparam logic [63:0] C2 = 64'hA4093822299F31D0;
    localparam logic [63:0] C3 = 64'h082EFA98EC4E6C89;
    localparam logic [63:0] C4 = 64'h452821E638D01377;
    localparam logic [63:0] C5 = 64'hBE5466CF34E90C6C;
    localparam logic [63:0] C6 = 64'hC0AC29B7C97C50DD;
    localparam logic [63:0] C7 = 64'h3F84D5B5B5470917;
    localparam logic [511:0] H_A = {8{64'h0F1E2D3C4B5A6978}};
    localparam logic [511:0] H_B = {8{64'h1122334455667788}};
    localparam logic [511:0] H_C = {8{64'hCAFEBABEDEADBEEF}};

    typedef struct {
        string          name;
        logic [1023:0]  m;
        logic [1023:0]  v;
        logic           last;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [63:0] ew[16];
    int          n_total = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    int          hs_cyc  = 0;
    int          cd_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] dw(input int i);
        logic [7:0] b;
        b = 8'h11 + 8'(i);
        return {8{b}};
    endfunction

    function automatic logic [1023:0] mk_v(input logic [511:0] h, input logic [127:0] t);
        return {h, C0, C1, C2, C3, t[63:0] ^ C4, t[63:0] ^ C5, t[127:64] ^ C6, t[127:64] ^ C7};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic check_wide(input string name, input logic [1023:0] got, input logic [1023:0] exp);
        int bad;
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            bad = 0;
            for (int w = 15; w >= 0; w--) begin
                if (got[1023 - 64*w -: 64] !== exp[1023 - 64*w -: 64]) bad = w;
            end
            $display("FAIL %s word %0d: got %h expected %h", name, bad,
                     got[1023 - 64*bad -: 64], exp[1023 - 64*bad -: 64]);
        end
    endtask

    task automatic clr_ew();
        for (int i = 0; i < 16; i++) ew[i] = 64'd0;
    endtask

    task automatic push_exp(input string name, input logic [511:0] h, input logic [127:0] t, input logic last);
        exp_t e;
        e.name = name;
        for (int i = 0; i < 16; i++) e.m[1023 - 64*i -: 64] = ew[i];
        e.v    = mk_v(h, t);
        e.last = last;
        sbq.push_back(e);
    endtask

    // Monitor: every init_round pops one expected block and compares it.
    always @(negedge clk) begin
        if (rstb === 1'b1 && bus.init_round === 1'b1) begin
            if (sbq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_init_round: got init_round=1 expected no block issue");
            end else begin
                mon_e = sbq.pop_front();
                check_wide({mon_e.name, ".m_block"}, bus.m_block, mon_e.m);
                check_wide({mon_e.name, ".v_state"}, bus.v_state_init, mon_e.v);
                check({mon_e.name, ".last_block"}, 128'(bus.last_block), 128'(mon_e.last));
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int g;
        g = 0;
        @(negedge clk);
        bus.din = d; bus.din_last = last; bus.din_bytes = nb; bus.din_valid = 1'b1;
        while (bus.din_ready !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            n_total++;
            $display("FAIL send_timeout: got din_ready=%b expected 1 within 100 cycles", bus.din_ready);
        end
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        bus.din_valid = 1'b0; bus.din_last = 1'b0;
    endtask

    task automatic wait_init(input string name, input int exp_delta, input int ref_cyc);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (bus.init_round !== 1'b1 && g < 100);
        if (bus.init_round !== 1'b1) begin
            n_total++;
            $display("FAIL %s.init_timeout: got no init_round expected one within 100 cycles", name);
        end else begin
            check({name, ".latency"}, 128'(cyc - ref_cyc), 128'(exp_delta));
        end
    endtask

    task automatic pulse_cd(input logic [511:0] h);
        @(negedge clk);
        bus.h_chain = h; bus.count_done = 1'b1;
        @(posedge clk);
        #1;
        cd_cyc = cyc;
        bus.count_done = 1'b0;
    endtask

    task automatic do_abc(input string name);
        clr_ew();
        ew[0] = 64'h6162638000000000; ew[13] = 64'h1; ew[15] = 64'h18;
        push_exp(name, IVV, 128'h18, 1'b1);
        send(64'h6162630000000000, 1'b1, 4'd3);
        wait_init(name, 1, hs_cyc);
        check({name, ".v12"}, 128'(bus.v_state_init[255:192]), 128'h452821E638D0136F);
        check({name, ".v13"}, 128'(bus.v_state_init[191:128]), 128'hBE5466CF34E90C74);
        pulse_cd(H_A);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".din_ready"}, 128'(bus.din_ready), 128'd0);
        check({name, ".init_round"}, 128'(bus.init_round), 128'd0);
        check({name, ".busy"}, 128'(bus.busy), 128'd0);
        check({name, ".last_block"}, 128'(bus.last_block), 128'd0);
        check_wide({name, ".v_state"}, bus.v_state_init, 1024'd0);
        check_wide({name, ".m_block"}, bus.m_block, 1024'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 time units");
        $fatal(1);
    end

    initial begin
        bus.din = 64'd0; bus.din_valid = 1'b0; bus.din_last = 1'b0; bus.din_bytes = 4'd0;
        bus.h_chain = 512'd0; bus.count_done = 1'b0;
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rstb = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 128'(bus.din_ready), 128'd1);

        // "abc"
        do_abc("abc");

        // Empty message
        clr_ew();
        ew[0] = 64'h8000000000000000; ew[13] = 64'h1;
        push_exp("empty", IVV, 128'd0, 1'b1);
        send(64'hDEADBEEF00000000, 1'b1, 4'd0);
        wait_init("empty", 1, hs_cyc);
        pulse_cd(H_A);

        // 111 bytes: 13 full words plus a 7-byte tail
        clr_ew();
        for (int i = 0; i < 13; i++) ew[i] = dw(i);
        ew[13] = 64'hAABBCCDDEEFF1181; ew[15] = 64'h378;
        push_exp("b111", IVV, 128'h378, 1'b1);
        for (int i = 0; i < 13; i++) send(dw(i), 1'b0, 4'd8);
        send(64'hAABBCCDDEEFF1122, 1'b1, 4'd7);
        wait_init("b111", 1, hs_cyc);
        pulse_cd(H_A);

        // 112 bytes: pad byte in word 14, counter in an extra block
        clr_ew();
        for (int i = 0; i < 14; i++) ew[i] = dw(i);
        ew[14] = 64'h8000000000000000;
        push_exp("b112_blk1", IVV, 128'h380, 1'b0);
        clr_ew();
        ew[13] = 64'h1; ew[15] = 64'h380;
        push_exp("b112_blk2", H_B, 128'd0, 1'b1);
        for (int i = 0; i < 13; i++) send(dw(i), 1'b0, 4'd8);
        send(dw(13), 1'b1, 4'd8);
        wait_init("b112_blk1", 1, hs_cyc);
        pulse_cd(H_B);
        wait_init("b112_blk2", 2, cd_cyc);
        pulse_cd(H_A);

        // 128 bytes: no pad byte in block 1, 0x80 leads the extra block
        clr_ew();
        for (int i = 0; i < 16; i++) ew[i] = dw(i);
        push_exp("b128_blk1", IVV, 128'h400, 1'b0);
        clr_ew();
        ew[0] = 64'h8000000000000000; ew[13] = 64'h1; ew[15] = 64'h400;
        push_exp("b128_blk2", H_C, 128'd0, 1'b1);
        for (int i = 0; i < 15; i++) send(dw(i), 1'b0, 4'd8);
        send(dw(15), 1'b1, 4'd8);
        wait_init("b128_blk1", 1, hs_cyc);
        pulse_cd(H_C);
        wait_init("b128_blk2", 2, cd_cyc);
        pulse_cd(H_A);

        // 17 full words: second block chains from h_chain, t = 1088
        clr_ew();
        for (int i = 0; i < 16; i++) ew[i] = dw(i);
        push_exp("w17_blk1", IVV, 128'h400, 1'b0);
        clr_ew();
        ew[0] = dw(16); ew[1] = 64'h8000000000000000; ew[13] = 64'h1; ew[15] = 64'h440;
        push_exp("w17_blk2", H_B, 128'h440, 1'b1);
        for (int i = 0; i < 16; i++) send(dw(i), 1'b0, 4'd8);
        wait_init("w17_blk1", 1, hs_cyc);
        pulse_cd(H_B);
        @(negedge clk);
        check("w17_settle_ready", 128'(bus.din_ready), 128'd0);
        @(negedge clk);
        check("w17_fill_ready", 128'(bus.din_ready), 128'd1);
        send(dw(16), 1'b1, 4'd8);
        wait_init("w17_blk2", 1, hs_cyc);
        pulse_cd(H_A);

        // count_done while filling is ignored
        @(negedge clk);
        bus.count_done = 1'b1;
        @(negedge clk);
        bus.count_done = 1'b0;
        repeat (3) @(negedge clk);
        check("cd_in_fill_busy", 128'(bus.busy), 128'd0);
        check("cd_in_fill_ready", 128'(bus.din_ready), 128'd1);
        do_abc("abc_after_cd");

        // Reset while waiting on the round engine
        clr_ew();
        ew[0] = 64'h6162638000000000; ew[13] = 64'h1; ew[15] = 64'h18;
        push_exp("abc_pre_reset", IVV, 128'h18, 1'b1);
        send(64'h6162630000000000, 1'b1, 4'd3);
        wait_init("abc_pre_reset", 1, hs_cyc);
        repeat (2) @(negedge clk);
        check("wait_busy", 128'(bus.busy), 128'd1);
        rstb = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_in_wait");
        rstb = 1'b1;
        @(negedge clk);
        check("ready_after_reset2", 128'(bus.din_ready), 128'd1);
        do_abc("abc_after_reset");

        repeat (6) @(negedge clk);
        check("scoreboard_empty", 128'(sbq.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
